// File: rtl/gvt_if.sv
// Report/broadcast bundle between the GVT scheduler, the tile array and the GVT consumers.
// master = the scheduler; slave = the tile array / consumer side.
interface gvt_if #(
  parameter int N_TILES     = 16,
  parameter int TS_WIDTH    = 32,
  parameter int TB_WIDTH    = 32,
  parameter int EPOCH_WIDTH = 8
);
  logic                         enable;
  logic                         lvt_req;
  logic [N_TILES-1:0]           lvt_valid;
  logic [N_TILES-1:0]           lvt_ready;
  logic [N_TILES*TS_WIDTH-1:0]  lvt_ts;
  logic [N_TILES*TB_WIDTH-1:0]  lvt_tb;
  logic                         gvt_valid;
  logic [TS_WIDTH-1:0]          gvt_ts;
  logic [TB_WIDTH-1:0]          gvt_tb;
  logic [EPOCH_WIDTH-1:0]       gvt_round;
  logic                         gvt_regress;

  modport master (
    input  enable, lvt_valid, lvt_ts, lvt_tb,
    output lvt_req, lvt_ready, gvt_valid, gvt_ts, gvt_tb, gvt_round, gvt_regress
  );

  modport slave (
    output enable, lvt_valid, lvt_ts, lvt_tb,
    input  lvt_req, lvt_ready, gvt_valid, gvt_ts, gvt_tb, gvt_round, gvt_regress
  );
endinterface

// File: rtl/gvt_scheduler.sv
// Periodic GVT round controller: request LVTs from every tile, collect them, reduce to the
// lexicographic (ts, tb) minimum one tile per cycle, and publish it as the new GVT.
module gvt_scheduler #(
  parameter int N_TILES        = 16,
  parameter int TS_WIDTH       = 32,
  parameter int TB_WIDTH       = 32,
  parameter int LOG_GVT_PERIOD = 5,
  parameter int EPOCH_WIDTH    = 8
) (
  input  logic   clk,
  input  logic   rst,
  gvt_if.master  bus
);

  localparam int IDX_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam int PER_W = (LOG_GVT_PERIOD > 0) ? LOG_GVT_PERIOD : 1;
  localparam logic [PER_W-1:0] PERIOD_LOAD = PER_W'((1 << LOG_GVT_PERIOD) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_TILES - 1);

  typedef enum logic [2:0] {IDLE, WAIT, REQ, COLLECT, REDUCE, BCAST} state_t;

  state_t               state_q, state_d;
  logic [PER_W-1:0]     period_q;
  logic [N_TILES-1:0]   received_q, received_d;
  logic [N_TILES-1:0]   accept;
  logic [IDX_W-1:0]     idx_q;
  logic [TS_WIDTH-1:0]  acc_ts_q, acc_ts_d;
  logic [TB_WIDTH-1:0]  acc_tb_q, acc_tb_d;
  logic [TS_WIDTH-1:0]  lat_ts [N_TILES];
  logic [TB_WIDTH-1:0]  lat_tb [N_TILES];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    received_d = received_q;
    accept     = '0;
    case (state_q)
      IDLE:    if (bus.enable) state_d = WAIT;
      WAIT:    if (period_q == '0) state_d = bus.enable ? REQ : IDLE;
      REQ: begin
        received_d = '0;
        state_d    = COLLECT;
      end
      COLLECT: begin
        accept     = bus.lvt_valid & bus.lvt_ready;
        received_d = received_q | accept;
        // Leaving on the edge that completes the mask keeps reduction latency at N_TILES.
        if (&received_d) state_d = REDUCE;
      end
      REDUCE:  if (idx_q == LAST_IDX) state_d = BCAST;
      BCAST:   state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  // Concatenation gives the unsigned lexicographic (ts, tb) ordering directly.
  always_comb begin
    acc_ts_d = acc_ts_q;
    acc_tb_d = acc_tb_q;
    if ({lat_ts[idx_q], lat_tb[idx_q]} < {acc_ts_q, acc_tb_q}) begin
      acc_ts_d = lat_ts[idx_q];
      acc_tb_d = lat_tb[idx_q];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      period_q        <= '0;
      received_q      <= '0;
      idx_q           <= '0;
      acc_ts_q        <= '1;
      acc_tb_q        <= '1;
      bus.lvt_req     <= 1'b0;
      bus.lvt_ready   <= '0;
      bus.gvt_valid   <= 1'b0;
      bus.gvt_ts      <= '0;
      bus.gvt_tb      <= '0;
      bus.gvt_round   <= '0;
      bus.gvt_regress <= 1'b0;
    end else begin
      state_q       <= state_d;
      received_q    <= received_d;
      bus.lvt_req   <= (state_d == REQ);
      bus.lvt_ready <= (state_d == COLLECT) ? ~received_d : '0;
      bus.gvt_valid <= (state_d == BCAST);

      if (state_d == WAIT && state_q != WAIT) begin
        period_q <= PERIOD_LOAD;
      end else if (state_q == WAIT && period_q != '0) begin
        period_q <= period_q - 1'b1;
      end

      if (state_q == REDUCE) begin
        idx_q    <= idx_q + 1'b1;
        acc_ts_q <= acc_ts_d;
        acc_tb_q <= acc_tb_d;
      end else begin
        idx_q    <= '0;
        acc_ts_q <= '1;
        acc_tb_q <= '1;
      end

      // Publish on the final comparison so gvt_* and gvt_valid appear together.
      if (state_q == REDUCE && state_d == BCAST) begin
        bus.gvt_round <= bus.gvt_round + 1'b1;
        if ({acc_ts_d, acc_tb_d} >= {bus.gvt_ts, bus.gvt_tb}) begin
          bus.gvt_ts <= acc_ts_d;
          bus.gvt_tb <= acc_tb_d;
        end else begin
          bus.gvt_regress <= 1'b1;
        end
      end
    end
  end

  // NOTE: report storage is not reset; the received mask alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_TILES; i++) begin
      if (accept[i]) begin
        lat_ts[i] <= bus.lvt_ts[i*TS_WIDTH +: TS_WIDTH];
        lat_tb[i] <= bus.lvt_tb[i*TB_WIDTH +: TB_WIDTH];
      end
    end
  end

endmodule

// File: doc/gvt_scheduler.md
# gvt_scheduler

Periodic global-virtual-time (GVT) round controller for the Chronos tile array. Every 2^LOG_GVT_PERIOD cycles it requests a local-virtual-time (LVT) report from each of N_TILES tiles and collects all reports. It then reduces them sequentially to the lexicographic minimum (timestamp, tiebreaker) and broadcasts the result as the new GVT to the task units and commit queues. It sits at the top level beside the tile array and is the only writer of GVT.

## Interface
Parameters:
- N_TILES, 16, number of reporting tiles (≥1)
- TS_WIDTH, 32, timestamp width
- TB_WIDTH, 32, tiebreaker width
- LOG_GVT_PERIOD, 5, log2 of idle cycles between rounds
- EPOCH_WIDTH, 8, width of the round counter

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  level; rounds start only while high
- lvt_req  out  1  one-cycle pulse opening a collection round
- lvt_valid  in  N_TILES  per-tile report valid
- lvt_ready  out  N_TILES  per-tile report accept
- lvt_ts  in  N_TILES*TS_WIDTH  per-tile LVT timestamp; tile i at [i*TS_WIDTH +: TS_WIDTH]
- lvt_tb  in  N_TILES*TB_WIDTH  per-tile LVT tiebreaker, same packing
- gvt_valid  out  1  one-cycle pulse; new GVT published
- gvt_ts  out  TS_WIDTH  current GVT timestamp; held between pulses
- gvt_tb  out  TB_WIDTH  current GVT tiebreaker
- gvt_round  out  EPOCH_WIDTH  count of completed broadcasts, wraps
- gvt_regress  out  1  sticky error: computed GVT fell below published GVT

## Operation
- FSM states: IDLE, WAIT, REQ, COLLECT, REDUCE, BCAST.
- IDLE → WAIT when enable=1. On entering WAIT, the period counter loads 2^LOG_GVT_PERIOD−1.
- WAIT: the counter decrements each cycle. At 0: go to REQ if enable=1, else go to IDLE.
- REQ: lvt_req=1 for exactly one cycle, the `received` mask clears, then go to COLLECT. No reports are accepted in REQ.
- COLLECT:
  - lvt_ready[i] = !received[i].
  - On lvt_valid[i]&&lvt_ready[i], latch the tile's ts/tb and set received[i].
  - Several tiles may be accepted in the same cycle.
  - After a tile's bit is set, further valid from that tile in the round is ignored.
  - When the mask is all ones, go to REDUCE on the next edge.
- REDUCE:
  - idx runs 0..N_TILES−1, one comparison per cycle.
  - The accumulator starts at all-ones (ts, tb).
  - acc = (ts_i,tb_i) if ts_i<acc_ts, or if ts_i==acc_ts && tb_i<acc_tb.
  - Comparison is unsigned and lexicographic, ts then tb.
  - After idx=N_TILES−1, go to BCAST.
- BCAST, one cycle:
  - If acc ≥ current (gvt_ts,gvt_tb): update gvt_ts/gvt_tb to acc and set gvt_valid=1.
  - Otherwise gvt holds its value, gvt_regress is set, and gvt_valid=1 is still pulsed.
  - gvt_round increments modulo 2^EPOCH_WIDTH.
  - Then go to WAIT.
- An all-ones LVT means the tile is empty. If every tile reports all-ones, the GVT becomes all-ones, which is a legal terminal value.
- Dropping enable mid-round does not abort the round. The round completes through BCAST, then WAIT expires to IDLE.
- gvt_regress clears only on rst.

## Timing
- Reset values:
  - state=IDLE, lvt_req=0, lvt_ready=0, gvt_valid=0.
  - gvt_ts=0, gvt_tb=0, gvt_round=0, gvt_regress=0, received=0.
  - period counter=0.
- rst asserted mid-round returns everything to the reset values immediately. Partial reports are discarded.
- enable sampled high in IDLE at edge t: lvt_req is high in cycle t+1+2^LOG_GVT_PERIOD.
- lvt_ready goes high in the cycle after lvt_req.
- Last report accepted at edge t: gvt_valid is high in cycle t+N_TILES+1, and gvt_ts/gvt_tb are valid from that same cycle.
- Back-to-back rounds: the next lvt_req comes 2^LOG_GVT_PERIOD+1 cycles after the gvt_valid cycle.
- All outputs are registered.

## Test plan
- Reset, then enable=1 with all tiles replying the cycle after lvt_req, tile i reporting ts=100+i, tb=0 → gvt_valid once with gvt_ts=100, gvt_tb=0, gvt_round=1; lvt_req 33 cycles after enable (LOG_GVT_PERIOD=5).
- Tie-break: tiles 3 and 7 report ts=50 with tb=9 and tb=4, others ts=60 → gvt=(50,4).
- Staggered replies, tile 15 last at edge t, with a repeated valid from tile 0 carrying ts=1 → the repeat is ignored (lvt_ready[0]=0); gvt_valid at t+17.
- All tiles report all-ones → gvt_ts and gvt_tb are all-ones; a next round reporting ts=5 sets gvt_regress=1, gvt stays all-ones, gvt_valid still pulses.
- Drop enable during COLLECT → the round finishes and broadcasts, the FSM reaches IDLE, no further lvt_req.
- Assert rst during REDUCE → all outputs return to reset values next cycle; gvt_round=0, gvt_regress=0.
